// File: rtl/serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and
// counter-width helper.
package serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } ser_state_e;

    // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a valid/ready
// handshake and drives it one bit per clock on ser_out, followed by GAP idle
// cycles. word_done pulses with the last data bit of each word.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   GAP        = 1,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int BIT_CW = cnt_width(WIDTH);
    localparam int GAP_CW = cnt_width(GAP + 1);
    localparam logic [BIT_CW-1:0] BIT_LOAD = BIT_CW'(WIDTH - 1);
    localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

    ser_state_e        state_q,   state_d;
    logic [WIDTH-1:0]  shreg_q,   shreg_d;
    logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
    logic              ser_out_q, ser_out_d;

    logic last_bit;
    logic handshake;

    // Bit presented first from a word, honouring the configured bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    // Advance the shift register by one bit toward the output end.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    assign last_bit  = (state_q == S_SHIFT) && (bit_cnt_q == '0);
    // With no gap, the last-bit cycle doubles as an accept window so words
    // can stream without an idle bit between them.
    assign in_ready  = (state_q == S_IDLE) || ((GAP == 0) && last_bit);
    assign handshake = in_valid && in_ready;

    assign ser_out   = ser_out_q;
    assign ser_valid = (state_q == S_SHIFT);
    assign word_done = last_bit;
    assign busy      = (state_q != S_IDLE);

    // State, shift register, counters and registered serial output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ser_out_q <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ser_out_q <= ser_out_d;
        end
    end

    // Next-state, counter and next serial bit selection.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ser_out_d = IDLE_LEVEL;

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                gap_cnt_d = '0;
                if (handshake) begin
                    shreg_d   = in_data;
                    bit_cnt_d = BIT_LOAD;
                    ser_out_d = first_bit(in_data);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    shreg_d   = shift_word(shreg_q);
                    bit_cnt_d = bit_cnt_q - BIT_CW'(1);
                    ser_out_d = first_bit(shift_word(shreg_q));
                end else if (GAP > 0) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = S_GAP;
                end else if (handshake) begin
                    shreg_d   = in_data;
                    bit_cnt_d = BIT_LOAD;
                    ser_out_d = first_bit(in_data);
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three configurations (GAP=1 MSB-first,
// GAP=0 MSB-first, GAP=1 LSB-first), all WIDTH=4.
module tb_bit_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0] d_data = '0;
    logic d_valid = 1'b0, d_ready, d_ser, d_sval, d_done, d_busy;
    logic [3:0] g_data = '0;
    logic g_valid = 1'b0, g_ready, g_ser, g_sval, g_done, g_busy;
    logic [3:0] l_data = '0;
    logic l_valid = 1'b0, l_ready, l_ser, l_sval, l_done, l_busy;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(4), .GAP(1), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
        .ser_out(d_ser), .ser_valid(d_sval), .word_done(d_done), .busy(d_busy));

    bit_serializer #(.WIDTH(4), .GAP(0), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_g0 (
        .clk(clk), .rst(rst), .in_data(g_data), .in_valid(g_valid), .in_ready(g_ready),
        .ser_out(g_ser), .ser_valid(g_sval), .word_done(g_done), .busy(g_busy));

    bit_serializer #(.WIDTH(4), .GAP(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
        .ser_out(l_ser), .ser_valid(l_sval), .word_done(l_done), .busy(l_busy));

    // Downstream view: what a consumer clocking x on each rising edge captures.
    logic [3:0] x_hist = '0;
    int         x_cnt = 0;
    always @(posedge clk) begin
        if (d_sval) begin
            x_hist <= {x_hist[2:0], d_ser};
            x_cnt  <= x_cnt + 1;
        end
    end

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if ({d_ser, d_sval, d_done, d_busy} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_outputs: got ser/sval/done/busy=%b want 0000", {d_ser, d_sval, d_done, d_busy});
        end
        compared++;
        if ({g_busy, l_busy, g_ser, l_ser} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_other_inst: got %b want 0000", {g_busy, l_busy, g_ser, l_ser});
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({d_ready, g_ready, l_ready} !== 3'b111) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b want 111", {d_ready, g_ready, l_ready});
        end
    endtask

    task automatic test_single_word();
        logic [3:0] bits;
        bits = 4'b1011;
        d_data = 4'b1011; d_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            d_valid = 1'b0;
            compared++;
            if ({d_ser, d_sval, d_done, d_ready, d_busy} !== {bits[4-k], 1'b1, (k == 4), 1'b0, 1'b1}) begin
                mismatched++;
                $display("FAIL single_c%0d: got ser/sval/done/rdy/busy=%b want %b", k,
                         {d_ser, d_sval, d_done, d_ready, d_busy}, {bits[4-k], 1'b1, (k == 4), 1'b0, 1'b1});
            end
        end
        @(negedge clk);
        compared++;
        if ({d_ser, d_sval, d_done, d_ready, d_busy} !== 5'b00001) begin
            mismatched++;
            $display("FAIL single_gap: got %b want 00001", {d_ser, d_sval, d_done, d_ready, d_busy});
        end
        @(negedge clk);
        compared++;
        if ({d_ready, d_busy} !== 2'b10) begin
            mismatched++;
            $display("FAIL single_idle: got rdy/busy=%b want 10", {d_ready, d_busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'b1100_0011;
        g_data = 4'b1100; g_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            compared++;
            if ({g_ser, g_sval, g_done} !== {bits[8-k], 1'b1, (k == 4 || k == 8)}) begin
                mismatched++;
                $display("FAIL b2b_c%0d: got ser/sval/done=%b want %b", k,
                         {g_ser, g_sval, g_done}, {bits[8-k], 1'b1, (k == 4 || k == 8)});
            end
            if (k == 4) begin
                compared++;
                if (g_ready !== 1'b1) begin
                    mismatched++;
                    $display("FAIL b2b_ready_last: got %b want 1", g_ready);
                end
            end
            if (k == 1) g_data = 4'b0011;
            if (k == 5) g_valid = 1'b0;
        end
        @(negedge clk);
        compared++;
        if ({g_sval, g_busy, g_ready} !== 3'b001) begin
            mismatched++;
            $display("FAIL b2b_end: got sval/busy/rdy=%b want 001", {g_sval, g_busy, g_ready});
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] want;
        want = 4'b1000;  // ser_out sequence over cycles 1..4, first bit leftmost
        l_data = 4'b0001; l_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            l_valid = 1'b0;
            compared++;
            if ({l_ser, l_done} !== {want[4-k], (k == 4)}) begin
                mismatched++;
                $display("FAIL lsb_c%0d: got ser/done=%b want %b", k, {l_ser, l_done}, {want[4-k], (k == 4)});
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int dones;
        logic [11:0] want_ser;
        logic [11:0] want_val;
        dones = 0;
        want_ser = 12'b0000_0_0_1111_0_0;
        want_val = 12'b1111_0_0_1111_0_0;
        d_data = 4'h0; d_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) d_data = 4'hF;
            if (k == 7) d_valid = 1'b0;
            if (d_done === 1'b1) dones++;
            compared++;
            if ({d_ser, d_sval} !== {want_ser[12-k], want_val[12-k]}) begin
                mismatched++;
                $display("FAIL busy_ign_c%0d: got ser/sval=%b want %b", k,
                         {d_ser, d_sval}, {want_ser[12-k], want_val[12-k]});
            end
            if (k <= 5) begin
                compared++;
                if (d_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL busy_ign_ready_c%0d: got %b want 0", k, d_ready);
                end
            end
        end
        compared++;
        if (dones != 2 || d_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_ign_count: got done_pulses=%0d busy=%b want 2 0", dones, d_busy);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] bits;
        d_data = 4'b1010; d_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); d_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (d_ser !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_pre: got ser=%b want 1", d_ser);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({d_ser, d_busy, d_done, d_sval} !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_mid_async: got ser/busy/done/sval=%b want 0000", {d_ser, d_busy, d_done, d_sval});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if ({d_ready, d_busy} !== 2'b10) begin
            mismatched++;
            $display("FAIL rst_mid_release: got rdy/busy=%b want 10", {d_ready, d_busy});
        end
        bits = 4'b0110;
        d_data = 4'b0110; d_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            d_valid = 1'b0;
            compared++;
            if ({d_ser, d_done} !== {bits[4-k], (k == 4)}) begin
                mismatched++;
                $display("FAIL rst_mid_next_c%0d: got ser/done=%b want %b", k, {d_ser, d_done}, {bits[4-k], (k == 4)});
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_downstream_view();
        int base;
        base = x_cnt;
        d_data = 4'b1010; d_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); d_valid = 1'b0;
        // First bit is sampled downstream at the edge after the handshake edge.
        @(negedge clk);
        compared++;
        if (x_cnt - base != 1 || x_hist[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL downstream_first: got cnt=%0d x=%b want 1 1", x_cnt - base, x_hist[0]);
        end
        repeat (4) @(negedge clk);
        compared++;
        if (x_cnt - base != 4 || x_hist !== 4'b1010) begin
            mismatched++;
            $display("FAIL downstream_word: got cnt=%0d x=%b want 4 1010", x_cnt - base, x_hist);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lsb_first();
        test_busy_ignore();
        test_reset_mid_word();
        test_downstream_view();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
